red_pitaya_pid_slew: RTL and testbench

//  Output conditioning stage directly downstream of the MIMO PID, one per PID output channel, feeding the DAC stream.

---
 rtl/red_pitaya_pid_pkg.sv | 35 +++
 rtl/red_pitaya_slew_step.sv | 86 ++++++++
 rtl/red_pitaya_pid_slew.sv | 187 ++++++++++++++++++
 tb/tb_red_pitaya_pid_slew.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/red_pitaya_pid_pkg.sv
// -----------------------------------------------------------------------------
// red_pitaya_pid_pkg
// Shared types for the PID output conditioning (slew) stage.
//   PID_DW       : default signed sample width
//   slew_state_t : PARK / TRACK / HOLD / RAMP_DN state encoding (2 bit)
//   dto_t        : signed DAC sample at the default width
//   sat_inc32    : saturating 32-bit increment used by the statistics counters
// -----------------------------------------------------------------------------
package red_pitaya_pid_pkg;

    localparam int PID_DW = 14;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        PARK    = 2'd0,
        TRACK   = 2'd1,
        HOLD    = 2'd2,
        RAMP_DN = 2'd3
    } slew_state_t;

    typedef logic signed [PID_DW-1:0] dto_t;

    // Counter increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        logic [31:0] res;
        if (val == CNT_MAX) begin
            res = val;
        end else begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/red_pitaya_slew_step.sv
// -----------------------------------------------------------------------------
// red_pitaya_slew_step
// Combinational clamp + slew-step datapath for one output channel.
//   track  in  1   1: target is din clamped to [lo,hi]; 0: target is alt
//   din    in  DW  PID sample (signed)
//   lo/hi  in  DW  clamp window (signed); lo>hi forces target = lo
//   alt    in  DW  target when not tracking (park value or current output)
//   cur    in  DW  current output sample (signed)
//   step   in  DW-1 max |delta| per sample, 0 disables slew limiting
//   nxt    out DW  next output sample, always between cur and target
//   clamp  out 1   din was outside the window while tracking
//   slew   out 1   |target-cur| exceeded a non-zero step
// -----------------------------------------------------------------------------
module red_pitaya_slew_step #(
    parameter int DW = 14
) (
    input  logic                 track,
    input  logic signed [DW-1:0] din,
    input  logic signed [DW-1:0] lo,
    input  logic signed [DW-1:0] hi,
    input  logic signed [DW-1:0] alt,
    input  logic signed [DW-1:0] cur,
    input  logic        [DW-2:0] step,
    output logic signed [DW-1:0] nxt,
    output logic                 clamp,
    output logic                 slew
);

    logic signed [DW-1:0] tgt_s;
    logic signed [DW:0]   tgt_x_s;
    logic signed [DW:0]   cur_x_s;
    logic signed [DW:0]   step_x_s;
    logic signed [DW:0]   diff_s;
    logic signed [DW:0]   sum_s;

    // Target selection and window clamp; an inverted window pins to lo.
    always_comb begin
        tgt_s = alt;
        clamp = 1'b0;
        if (track) begin
            if (lo > hi) begin
                tgt_s = lo;
                clamp = 1'b1;
            end else if (din < lo) begin
                tgt_s = lo;
                clamp = 1'b1;
            end else if (din > hi) begin
                tgt_s = hi;
                clamp = 1'b1;
            end else begin
                tgt_s = din;
                clamp = 1'b0;
            end
        end else begin
            tgt_s = alt;
            clamp = 1'b0;
        end
    end

    // Step limiter; difference is formed one bit wider so it cannot wrap.
    always_comb begin
        tgt_x_s  = {tgt_s[DW-1], tgt_s};
        cur_x_s  = {cur[DW-1], cur};
        step_x_s = {2'b00, step};
        diff_s   = tgt_x_s - cur_x_s;
        sum_s    = tgt_x_s;
        nxt      = tgt_s;
        slew     = 1'b0;
        if (step == {(DW-1){1'b0}}) begin
            nxt  = tgt_s;
            slew = 1'b0;
        end else if (diff_s > step_x_s) begin
            sum_s = cur_x_s + step_x_s;
            nxt   = sum_s[DW-1:0];
            slew  = 1'b1;
        end else if (diff_s < -step_x_s) begin
            sum_s = cur_x_s - step_x_s;
            nxt   = sum_s[DW-1:0];
            slew  = 1'b1;
        end else begin
            nxt  = tgt_s;
            slew = 1'b0;
        end
    end

endmodule

// File: rtl/red_pitaya_pid_slew.sv
// -----------------------------------------------------------------------------
// red_pitaya_pid_slew
// Output conditioning stage between a PID output channel and the DAC stream.
// Clamps each sample to [cfg_lo,cfg_hi], limits per-sample change to cfg_step
// and sequences PARK/TRACK/HOLD/RAMP_DN so the actuator never jumps.
//   clk, rstn (synchronous, active-low)
//   sti_*     : AXI-stream style input (tdata signed DW)
//   sto_*     : AXI-stream style output, single register stage, latency 1
//   cfg_*     : enable, hold, window, park value, step (sampled on acceptance)
//   sts_state : current state, sts_clamp / sts_slew : one-cycle event flags
// Build option PID_SLEW_STAT_EN adds cfg_cnt_clr, sts_cnt_clamp and
// sts_cnt_slew (saturating event counters, clear wins over increment).
// -----------------------------------------------------------------------------
module red_pitaya_pid_slew
    import red_pitaya_pid_pkg::*;
#(
    parameter int DW = PID_DW
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic signed [DW-1:0] sti_tdata,
    input  logic                 sti_tvalid,
    output logic                 sti_tready,
    output logic signed [DW-1:0] sto_tdata,
    output logic                 sto_tvalid,
    input  logic                 sto_tready,
    input  logic                 cfg_en,
    input  logic                 cfg_hold,
    input  logic signed [DW-1:0] cfg_lo,
    input  logic signed [DW-1:0] cfg_hi,
    input  logic signed [DW-1:0] cfg_park,
    input  logic        [DW-2:0] cfg_step,
    output logic        [1:0]    sts_state,
    output logic                 sts_clamp,
    output logic                 sts_slew
`ifdef PID_SLEW_STAT_EN
    ,
    input  logic                 cfg_cnt_clr,
    output logic        [31:0]   sts_cnt_clamp,
    output logic        [31:0]   sts_cnt_slew
`endif
);

    slew_state_t          state_r;
    slew_state_t          state_pre_s;
    slew_state_t          state_nxt_s;
    logic                 accept_s;
    logic signed [DW-1:0] alt_s;
    logic signed [DW-1:0] nxt_s;
    logic                 clamp_s;
    logic                 slew_s;

    assign sti_tready = !sto_tvalid | sto_tready;
    assign accept_s   = sti_tvalid & sti_tready;
    assign sts_state  = state_r;

    // Enable/hold transitions; the resulting state selects this sample's target.
    always_comb begin
        state_pre_s = state_r;
        case (state_r)
            PARK: begin
                if (cfg_en) begin
                    state_pre_s = TRACK;
                end else begin
                    state_pre_s = PARK;
                end
            end
            TRACK: begin
                if (!cfg_en) begin
                    state_pre_s = RAMP_DN;
                end else if (cfg_hold) begin
                    state_pre_s = HOLD;
                end else begin
                    state_pre_s = TRACK;
                end
            end
            HOLD: begin
                if (!cfg_en) begin
                    state_pre_s = RAMP_DN;
                end else if (!cfg_hold) begin
                    state_pre_s = TRACK;
                end else begin
                    state_pre_s = HOLD;
                end
            end
            RAMP_DN: begin
                if (cfg_en) begin
                    state_pre_s = TRACK;
                end else begin
                    state_pre_s = RAMP_DN;
                end
            end
            default: begin
                state_pre_s = PARK;
            end
        endcase
    end

    // HOLD freezes at the current output; PARK/RAMP_DN head for the park value.
    always_comb begin
        if (state_pre_s == HOLD) begin
            alt_s = sto_tdata;
        end else begin
            alt_s = cfg_park;
        end
    end

    red_pitaya_slew_step #(
        .DW (DW)
    ) u_step (
        .track (state_pre_s == TRACK),
        .din   (sti_tdata),
        .lo    (cfg_lo),
        .hi    (cfg_hi),
        .alt   (alt_s),
        .cur   (sto_tdata),
        .step  (cfg_step),
        .nxt   (nxt_s),
        .clamp (clamp_s),
        .slew  (slew_s)
    );

    // Ramp-down completes on the sample that lands on the park value.
    always_comb begin
        state_nxt_s = state_r;
        if (accept_s) begin
            if ((state_pre_s == RAMP_DN) && (nxt_s == cfg_park)) begin
                state_nxt_s = PARK;
            end else begin
                state_nxt_s = state_pre_s;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= PARK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output register, handshake and one-cycle status flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sto_tvalid <= 1'b0;
            sto_tdata  <= {DW{1'b0}};
            sts_clamp  <= 1'b0;
            sts_slew   <= 1'b0;
        end else if (accept_s) begin
            sto_tvalid <= 1'b1;
            sto_tdata  <= nxt_s;
            sts_clamp  <= clamp_s;
            sts_slew   <= slew_s;
        end else begin
            if (sto_tready) begin
                sto_tvalid <= 1'b0;
            end
            sts_clamp <= 1'b0;
            sts_slew  <= 1'b0;
        end
    end

`ifdef PID_SLEW_STAT_EN
    // Saturating event counters; clear takes priority over a pending event.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sts_cnt_clamp <= 32'd0;
            sts_cnt_slew  <= 32'd0;
        end else if (cfg_cnt_clr) begin
            sts_cnt_clamp <= 32'd0;
            sts_cnt_slew  <= 32'd0;
        end else begin
            if (sts_clamp) begin
                sts_cnt_clamp <= sat_inc32(sts_cnt_clamp);
            end
            if (sts_slew) begin
                sts_cnt_slew <= sat_inc32(sts_cnt_slew);
            end
        end
    end
`endif

endmodule

// File: tb/tb_red_pitaya_pid_slew.sv
// -----------------------------------------------------------------------------
// tb_red_pitaya_pid_slew
// Directed testbench for red_pitaya_pid_slew with hand-computed expectations.
// Define PID_SLEW_STAT_EN to also exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_red_pitaya_pid_slew;

    localparam int DW = 14;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic signed [DW-1:0] sti_tdata;
    logic                 sti_tvalid;
    logic                 sti_tready;
    logic signed [DW-1:0] sto_tdata;
    logic                 sto_tvalid;
    logic                 sto_tready;
    logic                 cfg_en;
    logic                 cfg_hold;
    logic signed [DW-1:0] cfg_lo;
    logic signed [DW-1:0] cfg_hi;
    logic signed [DW-1:0] cfg_park;
    logic        [DW-2:0] cfg_step;
    logic        [1:0]    sts_state;
    logic                 sts_clamp;
    logic                 sts_slew;
`ifdef PID_SLEW_STAT_EN
    logic                 cfg_cnt_clr;
    logic        [31:0]   sts_cnt_clamp;
    logic        [31:0]   sts_cnt_slew;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int xfer_n = 0;
    int xfer_last = 0;
    int xfer_base;

    red_pitaya_pid_slew #(.DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sti_tdata  (sti_tdata),
        .sti_tvalid (sti_tvalid),
        .sti_tready (sti_tready),
        .sto_tdata  (sto_tdata),
        .sto_tvalid (sto_tvalid),
        .sto_tready (sto_tready),
        .cfg_en     (cfg_en),
        .cfg_hold   (cfg_hold),
        .cfg_lo     (cfg_lo),
        .cfg_hi     (cfg_hi),
        .cfg_park   (cfg_park),
        .cfg_step   (cfg_step),
        .sts_state  (sts_state),
        .sts_clamp  (sts_clamp),
        .sts_slew   (sts_slew)
`ifdef PID_SLEW_STAT_EN
        ,
        .cfg_cnt_clr   (cfg_cnt_clr),
        .sts_cnt_clamp (sts_cnt_clamp),
        .sts_cnt_slew  (sts_cnt_slew)
`endif
    );

    always #5 clk = ~clk;

    // Output transfer monitor.
    always @(posedge clk) begin
        if (rstn && sto_tvalid && sto_tready) begin
            xfer_n    <= xfer_n + 1;
            xfer_last <= int'(sto_tdata);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d);
        sti_tdata  = DW'(d);
        sti_tvalid = 1'b1;
        @(posedge clk);
        #1;
        sti_tvalid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rstn       = 1'b0;
        sti_tdata  = '0;
        sti_tvalid = 1'b0;
        sto_tready = 1'b1;
        cfg_en     = 1'b0;
        cfg_hold   = 1'b0;
        cfg_lo     = -14'sd100;
        cfg_hi     = 14'sd100;
        cfg_park   = 14'sd0;
        cfg_step   = 13'd0;
`ifdef PID_SLEW_STAT_EN
        cfg_cnt_clr = 1'b0;
`endif
        tick();
        tick();
        chk("rst_valid", int'(sto_tvalid), 0);
        chk("rst_data",  int'(sto_tdata), 0);
        chk("rst_state", int'(sts_state), 0);
        chk("rst_clamp", int'(sts_clamp), 0);
        chk("rst_slew",  int'(sts_slew), 0);

        // Clamp on first tracked sample, no slew limit.
        rstn   = 1'b1;
        cfg_en = 1'b1;
        send(500);
        chk("clamp_data",  int'(sto_tdata), 100);
        chk("clamp_valid", int'(sto_tvalid), 1);
        chk("clamp_flag",  int'(sts_clamp), 1);
        chk("clamp_slew",  int'(sts_slew), 0);
        chk("clamp_state", int'(sts_state), 1);
        tick();
        chk("clamp_pulse", int'(sts_clamp), 0);
        chk("valid_drop",  int'(sto_tvalid), 0);

        // Slew limiting from cur=0.
        rstn = 1'b0;
        tick();
        rstn     = 1'b1;
        cfg_step = 13'd10;
        begin
            int exp_d [4] = '{10, 20, 30, 35};
            int exp_s [4] = '{1, 1, 1, 0};
            for (int i = 0; i < 4; i++) begin
                send(35);
                chk("slew_data", int'(sto_tdata), exp_d[i]);
                chk("slew_flag", int'(sts_slew), exp_s[i]);
            end
        end

        // Ramp down to park, then re-enable mid-ramp.
        cfg_step = 13'd0;
        send(50);
        chk("trk50", int'(sto_tdata), 50);
        cfg_en   = 1'b0;
        cfg_step = 13'd20;
        begin
            int exp_d [3] = '{30, 10, 0};
            int exp_st [3] = '{3, 3, 0};
            for (int i = 0; i < 3; i++) begin
                send(77);
                chk("ramp_data",  int'(sto_tdata), exp_d[i]);
                chk("ramp_state", int'(sts_state), exp_st[i]);
            end
        end
        cfg_en   = 1'b1;
        cfg_step = 13'd0;
        send(50);
        chk("retrk50", int'(sto_tdata), 50);
        cfg_en   = 1'b0;
        cfg_step = 13'd20;
        send(0);
        chk("ramp2_data",  int'(sto_tdata), 30);
        chk("ramp2_state", int'(sts_state), 3);
        cfg_en = 1'b1;
        send(100);
        chk("reen_data",  int'(sto_tdata), 50);
        chk("reen_state", int'(sts_state), 1);
        chk("reen_slew",  int'(sts_slew), 1);

        // Hold at 42, then disable while holding.
        cfg_step = 13'd0;
        send(42);
        chk("hold_pre", int'(sto_tdata), 42);
        cfg_hold = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send(i);
            chk("hold_data", int'(sto_tdata), 42);
        end
        chk("hold_state", int'(sts_state), 2);
        cfg_en   = 1'b0;
        cfg_step = 13'd20;
        send(0);
        chk("holdoff_data",  int'(sto_tdata), 22);
        chk("holdoff_state", int'(sts_state), 3);
        send(0);
        chk("holdoff_data2", int'(sto_tdata), 2);
        send(0);
        chk("holdoff_data3",  int'(sto_tdata), 0);
        chk("holdoff_state3", int'(sts_state), 0);
        cfg_hold = 1'b0;

        // Backpressure: output must stay stable, nothing lost or duplicated.
        cfg_en   = 1'b1;
        cfg_step = 13'd0;
        tick();
        sto_tready = 1'b0;
        xfer_base  = xfer_n;
        send(60);
        chk("bp_first", int'(sto_tdata), 60);
        sti_tdata  = 14'sd70;
        sti_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_ready", int'(sti_tready), 0);
            chk("bp_data",  int'(sto_tdata), 60);
            chk("bp_valid", int'(sto_tvalid), 1);
        end
        sto_tready = 1'b1;
        tick();
        sti_tvalid = 1'b0;
        chk("bp_second", int'(sto_tdata), 70);
        tick();
        chk("bp_xfers", xfer_n - xfer_base, 2);
        chk("bp_last",  xfer_last, 70);
        chk("bp_idle",  int'(sto_tvalid), 0);

        // Reset mid-stream drops the in-flight sample.
        send(90);
        sti_tdata  = 14'sd77;
        sti_tvalid = 1'b1;
        rstn       = 1'b0;
        tick();
        chk("mrst_valid", int'(sto_tvalid), 0);
        chk("mrst_data",  int'(sto_tdata), 0);
        chk("mrst_state", int'(sts_state), 0);
        sti_tvalid = 1'b0;
        rstn       = 1'b1;

        // Inverted window pins the target to cfg_lo.
        cfg_lo = 14'sd50;
        cfg_hi = -14'sd50;
        send(0);
        chk("inv_data",  int'(sto_tdata), 50);
        chk("inv_clamp", int'(sts_clamp), 1);
        cfg_lo = -14'sd100;
        cfg_hi = 14'sd100;

`ifdef PID_SLEW_STAT_EN
        cfg_cnt_clr = 1'b1;
        tick();
        cfg_cnt_clr = 1'b0;
        chk("cnt_clr", int'(sts_cnt_clamp), 0);
        send(200);
        send(-200);
        send(300);
        tick();
        chk("cnt_clamp3", int'(sts_cnt_clamp), 3);
        send(500);
        cfg_cnt_clr = 1'b1;
        tick();
        cfg_cnt_clr = 1'b0;
        chk("cnt_clr_win", int'(sts_cnt_clamp), 0);
        tick();
        chk("cnt_after", int'(sts_cnt_clamp), 0);
        chk("cnt_slew",  int'(sts_cnt_slew), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
